// File: rtl/mul6u_err_pkg.sv
// Shared types and widths for the approximate-multiplier error accumulator.
// The worst-case tracker in mul6u_err_acc is enabled by MUL6U_ERR_ACC_WCE_EN.
package mul6u_err_pkg;

    localparam int OP_W   = 6;
    localparam int PROD_W = 12;
    localparam int CNT_W  = 14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [PROD_W-1:0] abs_diff(
        input logic [PROD_W-1:0] x,
        input logic [PROD_W-1:0] y
    );
        return (x >= y) ? (x - y) : (y - x);
    endfunction

endpackage

// File: rtl/mul6u_exact.sv
// Exact 6x6 unsigned reference product, purely combinational.
module mul6u_exact
    import mul6u_err_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] p
);

    assign p = PROD_W'(a) * PROD_W'(b);

endmodule

// File: rtl/mul6u_err_acc.sv
// Frame-based error accumulator comparing an approximate 6x6 multiplier with the exact product.
// Optional worst-case error tracking is built only when MUL6U_ERR_ACC_WCE_EN is defined.
module mul6u_err_acc
    import mul6u_err_pkg::*;
#(
    parameter int N_SAMPLES = 4096,
    parameter int SUM_W     = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    input  logic [PROD_W-1:0] approx_p,
    output logic              busy,
    output logic              done,
    output logic [SUM_W-1:0]  err_sum,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [PROD_W-1:0] wce,
    output logic [OP_W-1:0]   wce_a,
    output logic [OP_W-1:0]   wce_b
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);

    state_t             state_r;
    logic [CNT_W-1:0]   sample_cnt_r;
    logic               s1_valid_r;
    logic [PROD_W-1:0]  s1_err_r;
    logic [PROD_W-1:0]  exact_p_s;
    logic [PROD_W-1:0]  err_s;
    logic               accept_s;
    logic               start_clr_s;
    logic [SUM_W:0]     sum_ext_s;
    logic [SUM_W-1:0]   sum_sat_s;

    mul6u_exact u_exact (
        .a (a),
        .b (b),
        .p (exact_p_s)
    );

    // Error term, acceptance and saturating sum are all derived combinationally.
    always_comb begin
        err_s       = abs_diff(exact_p_s, approx_p);
        accept_s    = in_valid & in_ready;
        start_clr_s = start & ((state_r == ST_IDLE) | (state_r == ST_DONE));
        sum_ext_s   = {1'b0, err_sum} + (SUM_W + 1)'(s1_err_r);
        if (sum_ext_s[SUM_W]) begin
            sum_sat_s = {SUM_W{1'b1}};
        end else begin
            sum_sat_s = sum_ext_s[SUM_W-1:0];
        end
    end

    // Frame control FSM with registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            in_ready     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            sample_cnt_r <= {CNT_W{1'b0}};
        end else if (abort) begin
            state_r  <= ST_IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_r      <= ST_ACCUM;
                        in_ready     <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        sample_cnt_r <= {CNT_W{1'b0}};
                    end
                end
                ST_ACCUM: begin
                    if (accept_s) begin
                        if (sample_cnt_r == LAST_IDX) begin
                            state_r  <= ST_DRAIN;
                            in_ready <= 1'b0;
                        end else begin
                            sample_cnt_r <= sample_cnt_r + CNT_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    // Stage 2 consumes the last sample in the same cycle stage 1 empties.
                    if (!s1_valid_r) begin
                        state_r <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1: register the absolute error of each accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_err_r   <= {PROD_W{1'b0}};
        end else if (abort) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_err_r <= err_s;
            end
        end
    end

    // Stage 2: saturating error sum and nonzero-error count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sum <= {SUM_W{1'b0}};
            err_cnt <= {CNT_W{1'b0}};
        end else if (!abort) begin
            if (start_clr_s) begin
                err_sum <= {SUM_W{1'b0}};
                err_cnt <= {CNT_W{1'b0}};
            end else if (s1_valid_r) begin
                err_sum <= sum_sat_s;
                if (s1_err_r != {PROD_W{1'b0}}) begin
                    err_cnt <= err_cnt + CNT_W'(1);
                end
            end
        end
    end

`ifdef MUL6U_ERR_ACC_WCE_EN
    logic [OP_W-1:0] s1_a_r;
    logic [OP_W-1:0] s1_b_r;

    // Operands travel alongside the stage-1 error so the worst case can name them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_a_r <= {OP_W{1'b0}};
            s1_b_r <= {OP_W{1'b0}};
        end else if (accept_s && !abort) begin
            s1_a_r <= a;
            s1_b_r <= b;
        end
    end

    // Strict comparison keeps the first occurrence of a tied worst case.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wce   <= {PROD_W{1'b0}};
            wce_a <= {OP_W{1'b0}};
            wce_b <= {OP_W{1'b0}};
        end else if (!abort) begin
            if (start_clr_s) begin
                wce   <= {PROD_W{1'b0}};
                wce_a <= {OP_W{1'b0}};
                wce_b <= {OP_W{1'b0}};
            end else if (s1_valid_r && (s1_err_r > wce)) begin
                wce   <= s1_err_r;
                wce_a <= s1_a_r;
                wce_b <= s1_b_r;
            end
        end
    end
`else
    assign wce   = {PROD_W{1'b0}};
    assign wce_a = {OP_W{1'b0}};
    assign wce_b = {OP_W{1'b0}};
`endif

endmodule
